// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier.
package shift_add_multiplier_pkg;

   localparam int unsigned DefaultWidth = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/product bus of the shift-add multiplier.
interface shift_add_multiplier_if #(
   parameter int unsigned N = shift_add_multiplier_pkg::DefaultWidth
);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [2*N-1:0] p;

   modport master (output start, output a, output b, input busy, input done, input p);
   modport slave  (input start, input a, input b, output busy, output done, output p);

endinterface

// File: rtl/shift_add_multiplier_ripple_carry_adder.sv
// Existing 4-bit ripple-carry adder; sole arithmetic element of the multiplier.
module ripple_carry_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[4];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-add multiplier with start/done handshake.
// Optional SHIFT_ADD_ZERO_BYPASS_EN: zero operands finish in one cycle.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int unsigned N = DefaultWidth
) (
   input logic                   clk,
   input logic                   rst,
   shift_add_multiplier_if.slave bus
);

   localparam int unsigned CntW = $clog2(N + 1);

   state_e          state_q, state_d;
   logic [N-1:0]    mcand_q, mcand_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [N-1:0]    mq_q, mq_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]  p_q, p_d;

   logic [N-1:0]    addend;
   logic [N-1:0]    sum;
   logic            cout;
   logic [2*N-1:0]  shifted;

   assign addend = mq_q[0] ? mcand_q : '0;

   ripple_carry_adder u_adder (
      .a    (acc_q),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (cout)
   );

   // One right shift of the (2N+1)-bit {cout, sum, mq} drops the consumed multiplier bit.
   assign shifted = {cout, sum, mq_q[N-1:1]};

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               mcand_d = bus.a;
               acc_d   = '0;
               mq_d    = bus.b;
               cnt_d   = CntW'(N);
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
               if (bus.a == '0 || bus.b == '0) begin
                  state_d = StDone;
                  p_d     = '0;
               end else begin
                  state_d = StRun;
               end
`else
               state_d = StRun;
`endif
            end
         end
         StRun: begin
            {acc_d, mq_d} = shifted;
            cnt_d         = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
               p_d     = shifted;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mcand_q <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = (state_q == StDone);
   assign bus.p    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier; honours SHIFT_ADD_ZERO_BYPASS_EN.
module tb_shift_add_multiplier;
   import shift_add_multiplier_pkg::*;

   localparam int unsigned N = DefaultWidth;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   shift_add_multiplier_if #(.N(N)) bus ();

   shift_add_multiplier #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned latency(input int unsigned av, input int unsigned bv);
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
      if (av == 0 || bv == 0) return 1;
`endif
      return N + 1;
   endfunction

   // Issues one multiply from an IDLE cycle and returns in the first IDLE cycle after done.
   // poke re-asserts start with other operands in cycles t+2 and t+5, which must be ignored.
   task automatic run_mul(input logic [N-1:0] av, input logic [N-1:0] bv, input bit poke);
      int unsigned lat;
      int unsigned prod;
      lat  = latency(int'(av), int'(bv));
      prod = int'(av) * int'(bv);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      step();
      for (int i = 1; i <= int'(lat); i++) begin
         bus.start = poke && (i == 2 || i == 5);
         bus.a     = poke ? N'(2) : N'($urandom);
         bus.b     = poke ? N'(2) : N'($urandom);
         check($sformatf("busy a=%0h b=%0h cyc=%0d", av, bv, i), 32'(bus.busy), 32'd1);
         check($sformatf("done a=%0h b=%0h cyc=%0d", av, bv, i), 32'(bus.done),
               32'(i == int'(lat)));
         if (i == int'(lat)) check($sformatf("p a=%0h b=%0h", av, bv), 32'(bus.p), prod);
         step();
      end
      bus.start = 1'b0;
      check($sformatf("idle_busy a=%0h b=%0h", av, bv), 32'(bus.busy), 32'd0);
      check($sformatf("idle_done a=%0h b=%0h", av, bv), 32'(bus.done), 32'd0);
      check($sformatf("p_hold a=%0h b=%0h", av, bv), 32'(bus.p), prod);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      step();
      step();
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_p", 32'(bus.p), 32'd0);
      rst = 1'b0;
      step();

      run_mul(N'(3), N'(5), 1'b0);
      run_mul(N'(15), N'(15), 1'b0);
      run_mul(N'(15), N'(1), 1'b0);
      run_mul(N'(0), N'(9), 1'b0);
      run_mul(N'(7), N'(6), 1'b1);

      // Abort a multiply with reset at edge t+3.
      bus.start = 1'b1;
      bus.a     = N'(10);
      bus.b     = N'(11);
      step();
      bus.start = 1'b0;
      check("abort_busy_t1", 32'(bus.busy), 32'd1);
      step();
      check("abort_busy_t2", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_p", 32'(bus.p), 32'd0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("abort_quiet cyc=%0d", i), 32'({bus.busy, bus.done}), 32'd0);
         step();
      end

      run_mul(N'(2), N'(3), 1'b0);

      // Reset wins over start on the same edge.
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = N'(5);
      bus.b     = N'(5);
      step();
      rst       = 1'b0;
      bus.start = 1'b0;
      check("rst_over_start_busy", 32'(bus.busy), 32'd0);
      check("rst_over_start_p", 32'(bus.p), 32'd0);

      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            run_mul(N'(ai), N'(bi), 1'b0);
         end
      end

      // Random operands with random idle gaps and noisy idle inputs.
      for (int k = 0; k < 40; k++) begin
         int unsigned gap;
         gap = $urandom_range(3, 0);
         for (int g = 0; g < int'(gap); g++) begin
            bus.a = N'($urandom);
            bus.b = N'($urandom);
            check("gap_busy", 32'(bus.busy), 32'd0);
            step();
         end
         run_mul(N'($urandom), N'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned N×N multiplier built around the team's 4-bit ripple-carry adder, which it instantiates as its only arithmetic element. Each RUN cycle it feeds the adder the partial product and the multiplicand, consumes the adder's sum and carry-out, and shifts the result one bit right. It sits directly downstream of the adder stage and turns that combinational adder into a clocked multiply unit with a start/done handshake.

## Interface
- N, default 4: operand width. Only 4 is supported in this revision because the adder sub-module is fixed at 4 bits.
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request a multiply. Sampled only in IDLE.
- a  in  N: multiplicand. Captured on the edge that accepts start.
- b  in  N: multiplier. Captured on the edge that accepts start.
- busy  out  1: high whenever the state is not IDLE.
- done  out  1: one-cycle pulse; product valid.
- p  out  2N: product. Registered and held until the next completion.

## Operation
- Registers:
  - mcand[N-1:0]
  - acc[N-1:0], the high half of the partial product
  - mq[N-1:0], the multiplier, becoming the low product half
  - cnt, width clog2(N+1)
  - state
- States are IDLE, RUN and DONE.
- IDLE:
  - If start=1: mcand←a, acc←0, mq←b, cnt←N, go to RUN.
  - Otherwise hold. p keeps its last value.
- RUN, every cycle:
  - Adder inputs are acc and (mq[0] ? mcand : 0), with cin=0, giving {cout,s}.
  - {acc,mq} ← {cout,s,mq[N-1:1]}, a single right shift of the (2N+1)-bit concatenation.
  - cnt ← cnt−1.
  - When cnt=1 at the edge, go to DONE.
- DONE, one cycle only:
  - p ← {acc,mq}, loaded on the edge entering DONE, so p is valid in the DONE cycle.
  - done=1, then go to IDLE.
- start is ignored while busy=1. This includes the DONE cycle, so no queuing occurs.
- Changes to a or b after acceptance have no effect.
- Arithmetic is unsigned and the product is exact. The maximum is (2^N−1)², so 0xE1 for N=4, with no overflow possible.
- rst=1 at any edge:
  - state←IDLE; acc, mq, mcand, cnt, p ← 0; done←0; busy←0.
  - A multiply in progress is aborted and produces no done pulse.
- rst has priority over start on the same edge.

## Timing
- Reset values: busy=0, done=0, p=0.
- start is accepted at edge t:
  - busy=1 from cycle t+1.
  - RUN occupies cycles t+1..t+N.
  - DONE is cycle t+N+1: done=1, p valid.
  - IDLE and busy=0 from cycle t+N+2.
- Latency from accepting edge to done is N+1 cycles, i.e. 5 for N=4.
- Maximum throughput is one multiply per N+2 cycles.
- The earliest next start is accepted at edge t+N+2.
- done is high for exactly one cycle. p remains stable until the next DONE entry or rst.
- The adder path is combinational within one cycle: acc→adder→acc.

## Configuration
- SHIFT_ADD_ZERO_BYPASS_EN defined:
  - In IDLE with start=1 and (a==0 or b==0), go directly to DONE with p←0.
  - done is then asserted in cycle t+1, a latency of 1.
- Not defined: every operand pair takes the full N+1 cycles, zero operands included.
- Non-zero operands behave identically either way.

## Structure
- Shared package or header holds:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The default width constant 4.
- One sub-module: ripple_carry_adder, the existing 4-bit adder, with ports a, b, cin, s and cout. It is instantiated once and its cin is tied to 0.
- Everything else is in this module:
  - the FSM
  - the shift datapath
  - cnt
  - the p register

## Test plan
- a=3, b=5, start at edge t → done only in cycle t+5, p=0x0F, busy=1 in cycles t+1..t+5.
- a=0xF, b=0xF → p=0xE1. Then a=0xF, b=0x1 → p=0x0F, with the second start issued at edge t+6 and accepted.
- a=0, b=9:
  - without the macro → done at t+5, p=0
  - with SHIFT_ADD_ZERO_BYPASS_EN → done at t+1, p=0
- Start a=7, b=6, then pulse start with a=2, b=2 in cycles t+2 and t+5 → ignored; single done with p=0x2A.
- Start a=0xA, b=0xB, rst=1 at edge t+3 → busy=0, p=0, no done pulse. A subsequent a=2, b=3 → p=0x06.
- Exhaustive back-to-back run over all 256 (a,b) pairs → p equals a*b each time; exactly one done per start; done never occurs with busy=0.
